stream_mux_rr: RTL

- Parametrised N-channel to 1 streaming multiplexer with valid/ready handshake on every input and on the output.
- Generalises the 4:1 narrow-slice data mux in three ways: arbitrary channel count, arbitrary data width built from narrow slices, and a registered output stage.
- Channel choice is either an explicit select or round-robin arbitration.
- Sits between several producers (e.g. per-port request queues) and a single shared consumer.

---
 rtl/stream_mux_pkg.sv | 20 ++
 rtl/mux_n_1_slice.sv | 23 ++
 rtl/stream_mux_rr.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types, default sizes and helpers for the stream_mux_rr multiplexer.
// Contents: default parameter values, mode encoding and the round-robin
// pointer advance function.
package stream_mux_pkg;

  localparam int unsigned N_CH_DEF    = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned SLICE_W_DEF = 2;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  // Next round-robin start position after channel ptr was served.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/mux_n_1_slice.sv
// Narrow N_CH:1 combinational mux for one SLICE_W-bit slice of the datapath.
// Ports:
//   data_i  N_CH*SLICE_W  flattened slice inputs, channel k at [k*SLICE_W +: SLICE_W]
//   sel_i   SEL_W         channel index
//   data_o  SLICE_W       selected slice (zero when sel_i >= N_CH)
module mux_n_1_slice #(
  parameter  int unsigned N_CH    = 4,
  parameter  int unsigned SLICE_W = 2,
  localparam int unsigned SEL_W   = $clog2(N_CH)
) (
  input  logic [N_CH*SLICE_W-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [SLICE_W-1:0]      data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_i == SEL_W'(k)) data_o = data_i[k*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N_CH:1 valid/ready stream multiplexer with fixed-select or round-robin
// arbitration and a single registered output stage (one beat per cycle).
// Optional packet lock is enabled by defining STREAM_MUX_PKT_LOCK_EN: once a
// channel sends a beat without in_last, it keeps the grant until its last beat.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   mode         0 = fixed select via sel, 1 = round-robin
//   sel          channel index for fixed mode (>= N_CH selects nothing)
//   in_valid     per-channel valid
//   in_data      flattened channel data, channel k at [k*DATA_W +: DATA_W]
//   in_last      end-of-packet flag (packet lock build only)
//   in_ready     per-channel ready, combinational, at most one bit set
//   out_valid    registered output valid
//   out_data     registered output data
//   out_ch       channel that produced out_data
//   out_ready    consumer ready
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N_CH    = N_CH_DEF,
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  parameter  int unsigned SLICE_W = SLICE_W_DEF,
  localparam int unsigned SEL_W   = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  localparam int unsigned N_SLICE = DATA_W / SLICE_W;

  logic              can_load_c;
  logic              gnt_vld_c;
  logic [SEL_W-1:0]  gnt_idx_c;
  logic              xfer_c;
  logic [DATA_W-1:0] mux_data_c;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic              lock_q,    lock_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
`else
  logic unused_last;
  assign unused_last = ^in_last;
`endif

  assign can_load_c = !out_valid_q || out_ready;

  // Grant selection: fixed index, or first valid channel starting at rr_ptr.
  always_comb begin
    int unsigned cand;
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    cand      = 0;
    if (mux_mode_t'(mode) == MODE_FIXED) begin
      if (32'(sel) < N_CH) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = sel;
      end
    end else begin
      // Scan from farthest to nearest so the closest valid channel wins.
      for (int i = N_CH - 1; i >= 0; i--) begin
        cand = 32'(rr_ptr_q) + 32'(i);
        if (cand >= N_CH) cand = cand - N_CH;
        if (in_valid[SEL_W'(cand)]) begin
          gnt_vld_c = 1'b1;
          gnt_idx_c = SEL_W'(cand);
        end
      end
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      gnt_vld_c = 1'b1;
      gnt_idx_c = lock_ch_q;
    end
`endif
  end

  // Ready goes only to the granted channel and is independent of its valid.
  always_comb begin
    in_ready = '0;
    if (!rst && gnt_vld_c) in_ready[gnt_idx_c] = can_load_c;
  end

  assign xfer_c = |(in_ready & in_valid);

  // Datapath: one narrow mux per slice, all steered by the same grant.
  for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
    logic [N_CH*SLICE_W-1:0] slice_in;
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign slice_in[k*SLICE_W +: SLICE_W] = in_data[k*DATA_W + s*SLICE_W +: SLICE_W];
    end
    mux_n_1_slice #(
      .N_CH    (N_CH),
      .SLICE_W (SLICE_W)
    ) u_mux (
      .data_i (slice_in),
      .sel_i  (gnt_idx_c),
      .data_o (mux_data_c[s*SLICE_W +: SLICE_W])
    );
  end

  // Next-state for output register, round-robin pointer and packet lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data_c;
      out_ch_d    = gnt_idx_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer_c && mux_mode_t'(mode) == MODE_RR) begin
      rr_ptr_d = SEL_W'(rr_next(32'(gnt_idx_c), N_CH));
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer_c) begin
      lock_d    = !in_last[gnt_idx_c];
      lock_ch_d = gnt_idx_c;
      // Releasing a lock always hands priority to the next channel.
      if (lock_q && in_last[gnt_idx_c]) rr_ptr_d = SEL_W'(rr_next(32'(gnt_idx_c), N_CH));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
